// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader_pkg
//  Description : Shared types and constants for the boot-time RAM loader.
//                Holds the loader state encoding, the default byte count per
//                word and a helper for sizing byte-index counters.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_loader_pkg;

    // Loader state encoding. The FSM register is a plain logic [1:0] so the
    // localparam constants below are the values actually used in RTL; the
    // enum is kept for readable debug/waveform decoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES          = DEFAULT_DATA_W / 8;

    // A counter over n items needs at least one bit even when n == 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTE_IDX_W = idx_width(BYTES);

endpackage
`default_nettype wire

// File: rtl/ram_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader_byte_packer
//  Description : Little-endian byte-to-word assembler. Each accepted byte is
//                written into lane byte_idx (lane 0 = bits 7:0) and the index
//                advances; word_ready flags the byte that completes a word.
//  Ports       : clk, rst_n     clock / async active-low reset
//                clear          drop any partial word, index back to lane 0
//                load           a byte is transferred this cycle
//                data_in [7:0]  the byte being transferred
//                word           assembled word (valid once word_ready seen)
//                word_ready     this transfer fills the last lane
//  Revision    : 1.0  initial release
// ============================================================================
module ram_loader_byte_packer
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        data_in,
    output logic [DATA_W-1:0] word,
    output logic              word_ready
);

    localparam int NB = DATA_W / 8;
    localparam int IW = idx_width(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    logic [IW-1:0] r_idx;

    // Combinational so the FSM can leave COLLECT on the very edge that
    // captures the last byte.
    assign word_ready = load && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            word  <= '0;
        end else if (clear) begin
            r_idx <= '0;
            word  <= '0;
        end else if (load) begin
            // Explicit return to lane 0 keeps non-power-of-two widths correct.
            r_idx <= word_ready ? '0 : r_idx + 1'b1;
            for (int i = 0; i < NB; i++) begin
                if (r_idx == IW'(i)) begin
                    word[i*8 +: 8] <= data_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Boot-time feeder for the shared data-bus RAM. Packs a UART
//                byte stream into words and writes them at incrementing
//                addresses, holding the CPU halted while loading and keeping
//                an XOR checksum of every word written.
//  Ports       : clk, rst_n             clock / async active-low reset
//                start, abort           load control pulses
//                base_addr, word_count  load geometry, sampled on start
//                rx_data/rx_valid/rx_ready  byte stream handshake
//                addr, RAM_read, bus    RAM write port (bus is tri-state)
//                cpu_halt, busy, done   status
//                checksum               XOR of words written this load
//  Revision    : 1.0  initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              RAM_read,
    inout  wire  [DATA_W-1:0] bus,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FULL_LOAD = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W:0]   r_remaining;   // one extra bit so a full-depth load fits
    logic [DATA_W-1:0] w_word;
    logic              w_word_ready;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_abort_run;
    logic              w_clear;

    // Status decodes straight from the state register, so an async reset
    // drops every strobe and releases the bus without waiting for a clock.
    assign rx_ready = (r_state == ST_COLLECT);
    assign RAM_read = (r_state == ST_WRITE);
    assign busy     = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
    assign cpu_halt = busy;
    assign done     = (r_state == ST_DONE);

    assign bus = RAM_read ? w_word : {DATA_W{1'bz}};

    assign w_xfer      = rx_valid && rx_ready;
    // abort beats a simultaneous start from IDLE/DONE.
    assign w_start_ok  = start && !abort &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort_run = abort && busy;
    assign w_clear     = w_start_ok || w_abort_run;

    ram_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .load       (w_xfer),
        .data_in    (rx_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (abort)             w_next = ST_IDLE;
                else if (w_word_ready) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)                          w_next = ST_IDLE;
                else if (r_remaining == LAST_WORD)  w_next = ST_DONE;
                else                                w_next = ST_COLLECT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            addr        <= '0;
            checksum    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                addr        <= base_addr;
                r_remaining <= (word_count == '0) ? FULL_LOAD
                                                  : {1'b0, word_count};
                checksum    <= '0;
            end else if (r_state == ST_WRITE) begin
                // The strobe is already on the bus this cycle, so the write
                // is accounted for even when abort arrives alongside it.
                checksum    <= checksum ^ w_word;
                addr        <= addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_loader
//  Description : Self-checking bench for ram_loader: table of directed loads
//                plus hand-written abort, full-depth and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] PAT = 32'h5A5A_A5A5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] addr;
    logic              RAM_read;
    wire  [DATA_W-1:0] bus;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .addr       (addr),
        .RAM_read   (RAM_read),
        .bus        (bus),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    // Stand-in for the RAM output driver: owns the bus whenever the loader
    // is not writing, so any stray loader drive corrupts the pattern.
    assign bus = RAM_read ? {DATA_W{1'bz}} : PAT;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bus_bad = 0;
    logic [ADDR_W-1:0] ev_addr [$];
    logic [DATA_W-1:0] ev_data [$];
    int                ev_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RAM_read) begin
            ev_addr.push_back(addr);
            ev_data.push_back(bus);
            ev_cyc.push_back(cyc);
        end else if (bus !== PAT) begin
            bus_bad <= bus_bad + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        ev_addr.delete();
        ev_data.delete();
        ev_cyc.delete();
        bus_bad = 0;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("rx_ready_timeout", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= limit) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
        bit                stall;
        logic [63:0]       bytes;   // byte i at bits [8i+7:8i]
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] w0, w1;
        logic [ADDR_W-1:0] fin;
        logic [DATA_W-1:0] cks;
    } vec_t;

    vec_t vt [3];

    initial begin
        logic [DATA_W-1:0] model_cks;
        logic [7:0]        bv;

        vt[0] = '{base:10'h010, cnt:10'd2, stall:1'b0, bytes:64'hDDCCBBAA_44332211,
                  a0:10'h010, a1:10'h011, w0:32'h44332211, w1:32'hDDCCBBAA,
                  fin:10'h012, cks:32'h99FF99BB};
        vt[1] = '{base:10'h010, cnt:10'd2, stall:1'b1, bytes:64'hDDCCBBAA_44332211,
                  a0:10'h010, a1:10'h011, w0:32'h44332211, w1:32'hDDCCBBAA,
                  fin:10'h012, cks:32'h99FF99BB};
        vt[2] = '{base:10'h3FF, cnt:10'd2, stall:1'b0, bytes:64'h08070605_04030201,
                  a0:10'h3FF, a1:10'h000, w0:32'h04030201, w1:32'h08070605,
                  fin:10'h001, cks:32'h0C040404};

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_outputs", {rx_ready, RAM_read, cpu_halt, busy, done}, 5'b0);
        chk("rst_addr", addr, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_bus", bus, PAT);
        rst_n = 1'b1;
        @(negedge clk);

        // start + abort together from IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // ---------------- table-driven loads ----------------
        for (int v = 0; v < 3; v++) begin
            clear_mon();
            pulse_start(vt[v].base, vt[v].cnt);
            chk($sformatf("v%0d_halt", v), cpu_halt, 1);
            for (int i = 0; i < 4 * int'(vt[v].cnt); i++) begin
                send_byte(vt[v].bytes[i*8 +: 8]);
                if (vt[v].stall) @(negedge clk);
            end
            wait_done(50);
            chk($sformatf("v%0d_pulses", v), ev_addr.size(), 2);
            if (ev_addr.size() == 2) begin
                chk($sformatf("v%0d_a0", v), ev_addr[0], vt[v].a0);
                chk($sformatf("v%0d_w0", v), ev_data[0], vt[v].w0);
                chk($sformatf("v%0d_a1", v), ev_addr[1], vt[v].a1);
                chk($sformatf("v%0d_w1", v), ev_data[1], vt[v].w1);
                if (!vt[v].stall)
                    chk($sformatf("v%0d_spacing", v), ev_cyc[1] - ev_cyc[0], 5);
            end
            chk($sformatf("v%0d_fin_addr", v), addr, vt[v].fin);
            chk($sformatf("v%0d_checksum", v), checksum, vt[v].cks);
            chk($sformatf("v%0d_done_halt", v), {done, cpu_halt}, 2'b10);
            chk($sformatf("v%0d_bus_z", v), bus_bad, 0);
        end

        // ---------------- abort mid-word, then clean reload ----------------
        clear_mon();
        pulse_start(10'h020, 10'd3);
        send_byte(8'hF1);
        send_byte(8'hF2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, done, cpu_halt}, 3'b000);
        chk("abort_no_write", ev_addr.size(), 0);
        pulse_start(10'h020, 10'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start(10'h300, 10'd2);      // ignored while busy
        send_byte(8'h03);
        send_byte(8'h04);
        wait_done(50);
        chk("reload_pulses", ev_addr.size(), 1);
        if (ev_addr.size() == 1) begin
            chk("reload_addr", ev_addr[0], 10'h020);
            chk("reload_word", ev_data[0], 32'h04030201);
        end
        chk("reload_checksum", checksum, 32'h04030201);

        // ---------------- abort during WRITE: write still lands ----------------
        clear_mon();
        pulse_start(10'h040, 10'd3);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        abort = 1'b1;                    // state is WRITE here
        @(negedge clk);
        abort = 1'b0;
        chk("abortw_pulses", ev_addr.size(), 1);
        chk("abortw_state", {busy, done}, 2'b00);
        chk("abortw_addr", addr, 10'h041);
        chk("abortw_checksum", checksum, 32'h04030201);

        // ---------------- full depth ----------------
        clear_mon();
        model_cks = '0;
        pulse_start(10'h000, 10'd0);
        for (int k = 0; k < 1024; k++) begin
            if (k == 1023) begin
                @(negedge clk);
                chk("full_1023_pulses", ev_addr.size(), 1023);
                chk("full_not_done_early", done, 0);
            end
            for (int j = 0; j < 4; j++) begin
                bv = 8'(4 * k + j);
                send_byte(bv);
            end
            model_cks = model_cks ^ {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        end
        wait_done(50);
        chk("full_pulses", ev_addr.size(), 1024);
        chk("full_done", done, 1);
        chk("full_fin_addr", addr, 10'h000);
        chk("full_checksum", checksum, model_cks);
        chk("full_bus_z", bus_bad, 0);

        // ---------------- async reset mid-COLLECT ----------------
        pulse_start(10'h100, 10'd2);
        send_byte(8'hAB);
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {rx_ready, RAM_read, cpu_halt, busy, done}, 5'b0);
        chk("arst_addr_cks", {22'b0, addr, checksum}, 64'h0);
        chk("arst_bus", bus, PAT);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_stays_idle", {busy, rx_ready, RAM_read}, 3'b000);
        rx_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
